cacheline_adapter: RTL

// - Sits directly below a cache controller: converts its 256-bit line read/writeback requests and next-line prefetch requests into 64-bit burst transactions on the burst-memory port.
// - Returns assembled lines on mem_rdata/mem_resp for demand traffic and on prefetch_rdata/prefetch_rvalid for prefetches. One transaction in flight; demand traffic has priority.

---
 rtl/cacheline_adapter_pkg.sv | 21 ++
 rtl/cacheline_adapter_if.sv | 24 ++
 rtl/cacheline_adapter_line_deserializer.sv | 32 +++
 rtl/cacheline_adapter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/cacheline_adapter_pkg.sv
// rtl/cacheline_adapter_pkg.sv - shared state/kind types and beat geometry for the cache line burst adapter
package cache_types;

    localparam int BEATS      = 4;
    localparam int BEAT_CNT_W = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_BEATS,
        WR_BEATS,
        RESP
    } adapter_state_t;

    typedef enum logic [1:0] {
        DEMAND_RD,
        PREFETCH,
        WRITE
    } req_kind_t;

endpackage

// File: rtl/cacheline_adapter_if.sv
// rtl/cacheline_adapter_if.sv - burst-memory port between the line adapter and memory
interface cacheline_adapter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BEAT_BITS  = 64
);
    logic [ADDR_WIDTH-1:0] bmem_addr;
    logic                  bmem_read;
    logic                  bmem_write;
    logic [BEAT_BITS-1:0]  bmem_wdata;
    logic                  bmem_ready;
    logic [ADDR_WIDTH-1:0] bmem_raddr;
    logic [BEAT_BITS-1:0]  bmem_rdata;
    logic                  bmem_rvalid;

    modport master (
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport slave (
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/cacheline_adapter_line_deserializer.sv
// rtl/cacheline_adapter_line_deserializer.sv - beat counter and line assembly register for read bursts
module line_deserializer
    import cache_types::*;
#(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 beat_valid,
    input  logic [BEAT_BITS-1:0] beat_data,
    output logic [LINE_BITS-1:0] line,
    output logic                 last_beat
);

    logic [BEAT_CNT_W-1:0] beat_cnt;

    // Beat k lands at line[k*BEAT_BITS +: BEAT_BITS]; clearing also wipes any partial line.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            beat_cnt <= '0;
            line     <= '0;
        end else if (beat_valid) begin
            line[beat_cnt*BEAT_BITS +: BEAT_BITS] <= beat_data;
            beat_cnt                              <= beat_cnt + 1'b1;
        end
    end

    assign last_beat = beat_valid && (beat_cnt == BEAT_CNT_W'(BEATS - 1));

endmodule

// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - converts 256-bit line read/writeback/prefetch requests into 64-bit bursts
module cacheline_adapter
    import cache_types::*;
#(
    parameter int LINE_BITS  = 256,
    parameter int BEAT_BITS  = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [LINE_BITS-1:0]  mem_wdata,
    output logic [LINE_BITS-1:0]  mem_rdata,
    output logic                  mem_resp,
    input  logic                  prefetch,
    input  logic [ADDR_WIDTH-1:0] prefetch_addr,
    output logic [LINE_BITS-1:0]  prefetch_rdata,
    output logic                  prefetch_rvalid,
    output logic                  prefetch_busy,
    cacheline_adapter_if.master   bmem
);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BITS/8 - 1);

    adapter_state_t        state, state_n;
    req_kind_t             kind, kind_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [LINE_BITS-1:0]  wdata_q, wdata_n;
    logic [BEAT_CNT_W-1:0] wr_beat, wr_beat_n;
    logic                  deser_clear;
    logic                  beat_ok;
    logic                  rd_last;
    logic [LINE_BITS-1:0]  line;

    // Beats tagged with another address (or arriving outside RD_BEATS) belong to nobody and are dropped.
    assign beat_ok = (state == RD_BEATS) && bmem.bmem_rvalid && (bmem.bmem_raddr == addr_q);

    line_deserializer #(
        .LINE_BITS (LINE_BITS),
        .BEAT_BITS (BEAT_BITS)
    ) u_deser (
        .clk        (clk),
        .rst        (rst),
        .clear      (deser_clear),
        .beat_valid (beat_ok),
        .beat_data  (bmem.bmem_rdata),
        .line       (line),
        .last_beat  (rd_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            kind    <= DEMAND_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_beat <= '0;
        end else begin
            state   <= state_n;
            kind    <= kind_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            wr_beat <= wr_beat_n;
        end
    end

    always_comb begin
        state_n     = state;
        kind_n      = kind;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        wr_beat_n   = wr_beat;
        deser_clear = 1'b0;
        case (state)
            IDLE: begin
                // Writeback first so a dirty victim leaves before its replacement is fetched.
                if (mem_write) begin
                    kind_n    = WRITE;
                    addr_n    = mem_addr & LINE_MASK;
                    wdata_n   = mem_wdata;
                    wr_beat_n = '0;
                    state_n   = WR_BEATS;
                end else if (mem_read) begin
                    kind_n      = DEMAND_RD;
                    addr_n      = mem_addr & LINE_MASK;
                    deser_clear = 1'b1;
                    state_n     = RD_CMD;
                end else if (prefetch) begin
                    kind_n      = PREFETCH;
                    addr_n      = prefetch_addr & LINE_MASK;
                    deser_clear = 1'b1;
                    state_n     = RD_CMD;
                end
            end
            RD_CMD: begin
                if (bmem.bmem_ready) begin
                    state_n = RD_BEATS;
                end
            end
            RD_BEATS: begin
                if (rd_last) begin
                    state_n = RESP;
                end
            end
            WR_BEATS: begin
                if (bmem.bmem_ready) begin
                    if (wr_beat == BEAT_CNT_W'(BEATS - 1)) begin
                        state_n = RESP;
                    end else begin
                        wr_beat_n = wr_beat + 1'b1;
                    end
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bmem.bmem_addr  = addr_q;
    assign bmem.bmem_read  = (state == RD_CMD);
    assign bmem.bmem_write = (state == WR_BEATS);
    assign bmem.bmem_wdata = wdata_q[wr_beat*BEAT_BITS +: BEAT_BITS];

    assign mem_rdata       = line;
    assign prefetch_rdata  = line;
    assign mem_resp        = (state == RESP) && (kind != PREFETCH);
    assign prefetch_rvalid = (state == RESP) && (kind == PREFETCH);
    assign prefetch_busy   = (kind == PREFETCH) && ((state == RD_CMD) || (state == RD_BEATS));

endmodule
